regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 64, register data width.
REQ-002 SHALL have parameter NumRegs, default 32, number of architectural registers.
REQ-003 SHALL have parameter IndexWidth, default $clog2(NumRegs), register index width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 SHALL have port iss_valid  in  1  issue request valid.
REQ-007 SHALL have port iss_ready  out  1  issue request accepted this cycle when high with iss_valid.
REQ-008 SHALL have ports iss_rs1, iss_rs2, iss_rd  in  IndexWidth  source and destination indices.
REQ-009 SHALL have port iss_rd_we  in  1  issued instruction will write rd.
REQ-010 SHALL have port op_valid  out  1  operand bundle valid.
REQ-011 SHALL have port op_ready  in  1  consumer accepts bundle.
REQ-012 SHALL have ports op_rs1_data, op_rs2_data  out  DataWidth; op_rd  out  IndexWidth; op_rd_we  out  1.
REQ-013 SHALL have ports wb_valid  in  1; wb_addr  in  IndexWidth; wb_data  in  DataWidth  writeback result, always accepted.
REQ-014 SHALL have ports rf_writeEn  out  1; rf_writeAddr  out  IndexWidth; rf_writeData  out  DataWidth  register-file write port.
REQ-015 SHALL have ports rf_readAddr1, rf_readAddr2  out  IndexWidth; rf_readData1, rf_readData2  in  DataWidth  combinational-read register-file ports.

Function
REQ-016 SHALL drive rf_readAddr1/2 combinationally from iss_rs1/iss_rs2.
REQ-017 SHALL drive rf_writeEn = wb_valid && wb_addr != 0, rf_writeAddr = wb_addr, rf_writeData = wb_data, combinationally.
REQ-018 SHALL keep a busy bit per register: set on issue handshake when iss_rd_we && iss_rd != 0; cleared on wb_valid for wb_addr.
REQ-019 SHALL give set priority when an issue handshake sets and a writeback clears the same register in one cycle (bit ends 1).
REQ-020 SHALL never set busy for register 0; register 0 operand data SHALL always be zero.
REQ-021 SHALL deassert iss_ready when any of: rs1 busy, rs2 busy, rd busy (iss_rd_we), or output stage full and op_ready low; a source busy but written back this cycle is not a stall when forwarding is compiled in.
REQ-022 SHALL select operand per source: zero if index 0; else wb_data if wb_valid && wb_addr matches (forwarding); else rf_readData.
REQ-023 SHALL register the operand bundle on issue handshake; op_valid rises the cycle after acceptance (latency 1).
REQ-024 SHALL hold op_* stable while op_valid && !op_ready; op_valid falls after handshake unless a new issue is accepted the same cycle (back-to-back, full throughput).
REQ-025 SHALL perform a writeback to a non-busy register normally (written, no error).

Reset
REQ-026 SHALL, on rst low, asynchronously clear all busy bits, op_valid=0, op_rs1_data=0, op_rs2_data=0, op_rd=0, op_rd_we=0.
REQ-027 SHALL discard any held operand bundle on reset mid-transfer; iss_ready evaluates from cleared state the first cycle after release.

Configuration
REQ-028 SHALL honour macro RF_FWD_EN: defined -> writeback-to-issue bypass per REQ-022; undefined -> no bypass, a source matching a same-cycle writeback stalls one cycle and reads the committed value next cycle.

Structure
REQ-029 SHALL take DataWidth/NumRegs/IndexWidth defaults and the issue-request struct typedef from shared package regfile_pkg.
REQ-030 SHALL implement the busy-bit array as sub-module rf_scoreboard (set/clear ports, per-index busy query).

Verification
REQ-031 Reset: rst low mid-stream -> op_valid=0, all busy bits 0, iss_ready=1 after release with op_ready=1.
REQ-032 Write then read: wb x5=64'hDEAD_BEEF_0000_0001; next cycle issue rs1=5,rs2=0 -> op_rs1_data=64'hDEAD_BEEF_0000_0001, op_rs2_data=0.
REQ-033 RAW hazard: issue rd=7 we=1; issue rs1=7 -> iss_ready=0 until wb x7=64'h1234; with RF_FWD_EN operand 64'h1234 accepted in wb cycle, without it one cycle later.
REQ-034 x0: wb_valid addr=0 data=all ones -> rf_writeEn=0; issue rs1=0 -> op_rs1_data=0; issue rd=0 we=1 -> no stall on later rs1=0.
REQ-035 Backpressure: op_ready=0 for 3 cycles with op_valid=1 -> op_* stable, iss_ready=0; op_ready=1 -> one bundle per cycle thereafter.
REQ-036 Same-cycle set/clear: busy x9, wb x9 while issuing rd=9 -> busy x9 remains 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and issue-request type for the register-file access controller
//
// Purpose: default register-file geometry and the issue-request bundle type
// shared by regfile_access_ctrl and rf_scoreboard.
// Ports: none (package).
// Configuration macro used by the importing design: RF_FWD_EN.
package regfile_pkg;

  localparam int RF_DATA_W   = 64;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_IDX_W    = $clog2(RF_NUM_REGS);

  // Index fields are sized for up to 256 registers so the bundle type does
  // not depend on the instantiating module's IndexWidth.
  localparam int REQ_IDX_W = 8;

  typedef struct packed {
    logic [REQ_IDX_W-1:0] rs1;
    logic [REQ_IDX_W-1:0] rs2;
    logic [REQ_IDX_W-1:0] rd;
    logic                 rd_we;
  } iss_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy-bit scoreboard with set/clear and three query ports
//
// Purpose: one busy bit per architectural register. A set and a clear of the
// same register in one cycle leaves the bit set. Register 0 is never busy.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   set_en, set_idx        mark register busy (issued producer)
//   clr_en, clr_idx        mark register free (writeback)
//   q_a/q_b/q_c_idx        query indices
//   q_a/q_b/q_c_busy       busy state of the queried registers
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NumRegs    = RF_NUM_REGS,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [IndexWidth-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [IndexWidth-1:0] clr_idx,
  input  logic [IndexWidth-1:0] q_a_idx,
  input  logic [IndexWidth-1:0] q_b_idx,
  input  logic [IndexWidth-1:0] q_c_idx,
  output logic                  q_a_busy,
  output logic                  q_b_busy,
  output logic                  q_c_busy
);

  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    for (int i = 1; i < NumRegs; i++) begin
      if (set_en && set_idx == IndexWidth'(i)) begin
        w_busy_next[i] = 1'b1;
      end else if (clr_en && clr_idx == IndexWidth'(i)) begin
        w_busy_next[i] = 1'b0;
      end
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign q_a_busy = r_busy[q_a_idx];
  assign q_b_busy = r_busy[q_b_idx];
  assign q_c_busy = r_busy[q_c_idx];

endmodule

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - issue-stage register-file read, hazard stall and writeback control
//
// Purpose: reads two source operands for an issuing instruction, stalls on
// busy sources/destination or a full output stage, registers the operand
// bundle (latency 1, full throughput) and passes writebacks to the register
// file while clearing the scoreboard.
// Configuration: RF_FWD_EN defined -> same-cycle writeback forwarded to the
// issuing operands; undefined -> a matching writeback stalls one cycle.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   iss_valid/iss_ready, iss_rs1/rs2/rd, iss_rd_we   issue request
//   op_valid/op_ready, op_rs1_data/op_rs2_data, op_rd, op_rd_we   operand bundle
//   wb_valid, wb_addr, wb_data       writeback (always accepted)
//   rf_writeEn/Addr/Data             register-file write port
//   rf_readAddr1/2, rf_readData1/2   combinational register-file read ports
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int DataWidth  = RF_DATA_W,
  parameter int NumRegs    = RF_NUM_REGS,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  output logic                  iss_ready,
  input  logic [IndexWidth-1:0] iss_rs1,
  input  logic [IndexWidth-1:0] iss_rs2,
  input  logic [IndexWidth-1:0] iss_rd,
  input  logic                  iss_rd_we,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DataWidth-1:0]  op_rs1_data,
  output logic [DataWidth-1:0]  op_rs2_data,
  output logic [IndexWidth-1:0] op_rd,
  output logic                  op_rd_we,
  input  logic                  wb_valid,
  input  logic [IndexWidth-1:0] wb_addr,
  input  logic [DataWidth-1:0]  wb_data,
  output logic                  rf_writeEn,
  output logic [IndexWidth-1:0] rf_writeAddr,
  output logic [DataWidth-1:0]  rf_writeData,
  output logic [IndexWidth-1:0] rf_readAddr1,
  output logic [IndexWidth-1:0] rf_readAddr2,
  input  logic [DataWidth-1:0]  rf_readData1,
  input  logic [DataWidth-1:0]  rf_readData2
);

  iss_req_t              w_req;
  logic [IndexWidth-1:0] w_rs1, w_rs2, w_rd;
  logic                  w_rs1_busy, w_rs2_busy, w_rd_busy;
  logic                  w_wb_hit1, w_wb_hit2, w_wb_hit_rd;
  logic                  w_rs1_stall, w_rs2_stall, w_rd_stall;
  logic                  w_out_free, w_iss_fire;
  logic [DataWidth-1:0]  w_rs1_data, w_rs2_data;

  logic                  r_op_valid;
  logic [DataWidth-1:0]  r_op_rs1_data, r_op_rs2_data;
  logic [IndexWidth-1:0] r_op_rd;
  logic                  r_op_rd_we;

  assign w_req = '{rs1: REQ_IDX_W'(iss_rs1), rs2: REQ_IDX_W'(iss_rs2),
                   rd: REQ_IDX_W'(iss_rd), rd_we: iss_rd_we};
  assign w_rs1 = IndexWidth'(w_req.rs1);
  assign w_rs2 = IndexWidth'(w_req.rs2);
  assign w_rd  = IndexWidth'(w_req.rd);

  assign rf_readAddr1 = iss_rs1;
  assign rf_readAddr2 = iss_rs2;
  assign rf_writeEn   = wb_valid && (wb_addr != '0);
  assign rf_writeAddr = wb_addr;
  assign rf_writeData = wb_data;

  assign w_wb_hit1   = wb_valid && (wb_addr == w_rs1) && (w_rs1 != '0);
  assign w_wb_hit2   = wb_valid && (wb_addr == w_rs2) && (w_rs2 != '0);
  assign w_wb_hit_rd = wb_valid && (wb_addr == w_rd);

`ifdef RF_FWD_EN
  assign w_rs1_stall = w_rs1_busy && !w_wb_hit1;
  assign w_rs2_stall = w_rs2_busy && !w_wb_hit2;
`else
  // Without a bypass the register file still shows the old value this
  // cycle, so any matching writeback costs one cycle.
  assign w_rs1_stall = w_rs1_busy || w_wb_hit1;
  assign w_rs2_stall = w_rs2_busy || w_wb_hit2;
`endif

  // The destination's previous producer retiring this cycle frees it for a
  // new producer; the scoreboard's set priority keeps it marked busy.
  assign w_rd_stall = w_req.rd_we && w_rd_busy && !w_wb_hit_rd;

  assign w_out_free = !r_op_valid || op_ready;
  assign iss_ready  = w_out_free && !w_rs1_stall && !w_rs2_stall && !w_rd_stall;
  assign w_iss_fire = iss_valid && iss_ready;

  always_comb begin
    w_rs1_data = rf_readData1;
    w_rs2_data = rf_readData2;
`ifdef RF_FWD_EN
    if (w_wb_hit1) w_rs1_data = wb_data;
    if (w_wb_hit2) w_rs2_data = wb_data;
`endif
    if (w_rs1 == '0) w_rs1_data = '0;
    if (w_rs2 == '0) w_rs2_data = '0;
  end

  rf_scoreboard #(
    .NumRegs    (NumRegs),
    .IndexWidth (IndexWidth)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (w_iss_fire && w_req.rd_we && (w_rd != '0)),
    .set_idx  (w_rd),
    .clr_en   (wb_valid),
    .clr_idx  (wb_addr),
    .q_a_idx  (w_rs1),
    .q_b_idx  (w_rs2),
    .q_c_idx  (w_rd),
    .q_a_busy (w_rs1_busy),
    .q_b_busy (w_rs2_busy),
    .q_c_busy (w_rd_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_valid    <= 1'b0;
      r_op_rs1_data <= '0;
      r_op_rs2_data <= '0;
      r_op_rd       <= '0;
      r_op_rd_we    <= 1'b0;
    end else if (w_iss_fire) begin
      r_op_valid    <= 1'b1;
      r_op_rs1_data <= w_rs1_data;
      r_op_rs2_data <= w_rs2_data;
      r_op_rd       <= w_rd;
      r_op_rd_we    <= w_req.rd_we;
    end else if (op_ready) begin
      r_op_valid    <= 1'b0;
    end
  end

  assign op_valid    = r_op_valid;
  assign op_rs1_data = r_op_rs1_data;
  assign op_rs2_data = r_op_rs2_data;
  assign op_rd       = r_op_rd;
  assign op_rd_we    = r_op_rd_we;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - directed self-checking bench for regfile_access_ctrl
module tb_regfile_access_ctrl;

  localparam int DW = 64;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid, iss_ready, iss_rd_we;
  logic [IW-1:0] iss_rs1, iss_rs2, iss_rd;
  logic          op_valid, op_ready, op_rd_we;
  logic [DW-1:0] op_rs1_data, op_rs2_data;
  logic [IW-1:0] op_rd;
  logic          wb_valid;
  logic [IW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          rf_writeEn;
  logic [IW-1:0] rf_writeAddr, rf_readAddr1, rf_readAddr2;
  logic [DW-1:0] rf_writeData, rf_readData1, rf_readData2;

  logic [DW-1:0] tb_rf [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .op_rd(op_rd), .op_rd_we(op_rd_we),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_writeEn(rf_writeEn), .rf_writeAddr(rf_writeAddr), .rf_writeData(rf_writeData),
    .rf_readAddr1(rf_readAddr1), .rf_readAddr2(rf_readAddr2),
    .rf_readData1(rf_readData1), .rf_readData2(rf_readData2)
  );

  // Register-file model: combinational read, clocked write.
  assign rf_readData1 = tb_rf[rf_readAddr1];
  assign rf_readData2 = tb_rf[rf_readAddr2];
  always @(posedge clk) if (rf_writeEn) tb_rf[rf_writeAddr] <= rf_writeData;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [IW-1:0] rs1, input logic [IW-1:0] rs2,
                       input logic [IW-1:0] rd, input logic we);
    iss_valid = v; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_we = we;
  endtask

  task automatic wb(input logic v, input logic [IW-1:0] a, input logic [DW-1:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tb_rf[i] = '0;
    rst = 1'b0;
    op_ready = 1'b1;
    issue(0, 0, 0, 0, 0);
    wb(0, 0, '0);

    // Reset values
    #2;
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_op_rs1", op_rs1_data, 64'd0);
    chk("rst_op_rd", 64'(op_rd), 64'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_iss_ready", 64'(iss_ready), 64'd1);

    // Write x5 then read it back
    wb(1, 5, 64'hDEAD_BEEF_0000_0001);
    #1;
    chk("wb_x5_we", 64'(rf_writeEn), 64'd1);
    chk("wb_x5_addr", 64'(rf_writeAddr), 64'd5);
    chk("wb_x5_data", rf_writeData, 64'hDEAD_BEEF_0000_0001);
    tick();
    wb(0, 0, '0);
    issue(1, 5, 0, 1, 0);
    #1;
    chk("rd_x5_ready", 64'(iss_ready), 64'd1);
    chk("rd_x5_raddr1", 64'(rf_readAddr1), 64'd5);
    tick();
    issue(0, 0, 0, 0, 0);
    #1;
    chk("rd_x5_op_valid", 64'(op_valid), 64'd1);
    chk("rd_x5_rs1", op_rs1_data, 64'hDEAD_BEEF_0000_0001);
    chk("rd_x5_rs2", op_rs2_data, 64'd0);
    chk("rd_x5_rd", 64'(op_rd), 64'd1);
    chk("rd_x5_rd_we", 64'(op_rd_we), 64'd0);
    tick();
    chk("drain_op_valid", 64'(op_valid), 64'd0);

    // x0 handling
    wb(1, 0, '1);
    #1;
    chk("x0_wr_en", 64'(rf_writeEn), 64'd0);
    tick();
    wb(0, 0, '0);
    issue(1, 0, 0, 0, 1);
    #1;
    chk("x0_issue_ready", 64'(iss_ready), 64'd1);
    tick();
    issue(1, 0, 0, 2, 0);
    #1;
    chk("x0_op_rs1", op_rs1_data, 64'd0);
    chk("x0_no_stall", 64'(iss_ready), 64'd1);
    tick();
    issue(0, 0, 0, 0, 0);

    // RAW hazard on x7
    issue(1, 0, 0, 7, 1);
    #1;
    chk("raw_prod_ready", 64'(iss_ready), 64'd1);
    tick();
    issue(1, 7, 0, 3, 0);
    #1;
    chk("raw_stall_0", 64'(iss_ready), 64'd0);
    tick();
    chk("raw_stall_1", 64'(iss_ready), 64'd0);
    wb(1, 7, 64'h1234);
    #1;
`ifdef RF_FWD_EN
    chk("raw_fwd_ready", 64'(iss_ready), 64'd1);
    tick();
    wb(0, 0, '0);
    issue(0, 0, 0, 0, 0);
    #1;
    chk("raw_fwd_valid", 64'(op_valid), 64'd1);
    chk("raw_fwd_rs1", op_rs1_data, 64'h1234);
`else
    chk("raw_wbcyc_stall", 64'(iss_ready), 64'd0);
    tick();
    wb(0, 0, '0);
    #1;
    chk("raw_next_ready", 64'(iss_ready), 64'd1);
    tick();
    issue(0, 0, 0, 0, 0);
    #1;
    chk("raw_nofwd_valid", 64'(op_valid), 64'd1);
    chk("raw_nofwd_rs1", op_rs1_data, 64'h1234);
`endif
    tick();

    // Backpressure
    op_ready = 1'b0;
    issue(1, 5, 0, 4, 0);
    tick();
    issue(1, 0, 0, 6, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_op_valid", 64'(op_valid), 64'd1);
      chk("bp_op_rs1", op_rs1_data, 64'hDEAD_BEEF_0000_0001);
      chk("bp_op_rd", 64'(op_rd), 64'd4);
      chk("bp_iss_ready", 64'(iss_ready), 64'd0);
      tick();
    end
    op_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(iss_ready), 64'd1);
    tick();
    issue(1, 7, 0, 8, 0);
    #1;
    chk("bp_b2_valid", 64'(op_valid), 64'd1);
    chk("bp_b2_rd", 64'(op_rd), 64'd6);
    chk("bp_b3_ready", 64'(iss_ready), 64'd1);
    tick();
    issue(0, 0, 0, 0, 0);
    #1;
    chk("bp_b3_rd", 64'(op_rd), 64'd8);
    chk("bp_b3_rs1", op_rs1_data, 64'h1234);
    tick();
    chk("bp_drain_valid", 64'(op_valid), 64'd0);

    // Same-cycle set and clear of x9
    issue(1, 0, 0, 9, 1);
    tick();
    wb(1, 9, 64'h99);
    issue(1, 0, 0, 9, 1);
    #1;
    chk("sc_issue_ready", 64'(iss_ready), 64'd1);
    tick();
    wb(0, 0, '0);
    issue(1, 9, 0, 10, 0);
    #1;
    chk("sc_x9_still_busy", 64'(iss_ready), 64'd0);
    issue(0, 0, 0, 0, 0);
    wb(1, 9, 64'h55);
    tick();
    wb(0, 0, '0);
    tick();

    // Reset mid-transfer
    op_ready = 1'b0;
    issue(1, 0, 0, 11, 1);
    tick();
    issue(0, 0, 0, 0, 0);
    chk("mid_pre_valid", 64'(op_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(op_valid), 64'd0);
    chk("mid_rst_rd", 64'(op_rd), 64'd0);
    tick();
    rst = 1'b1;
    op_ready = 1'b1;
    issue(1, 11, 0, 12, 1);
    #1;
    chk("mid_post_ready", 64'(iss_ready), 64'd1);
    tick();
    issue(0, 0, 0, 0, 0);
    #1;
    chk("mid_post_valid", 64'(op_valid), 64'd1);
    chk("mid_post_rs1", op_rs1_data, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
